// File: rtl/program_counter_unit.sv
// Program counter stage: advances, branches or halts the PC once per instruction using phase strobes.
// Optional feature macro: PC_LINK_EN adds a LINK output holding the return address of the last taken jump.
module program_counter_unit #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FETCH,
  input  logic             DECODE,
  input  logic             EXECUTE,
  input  logic             COMMIT,
  input  logic             PC_EN,
  input  logic             JRX,
  input  logic             JMP_X,
  input  logic             CC_APPLYX,
  input  logic             CC_INVERTX,
  input  logic [1:0]       CC_SELECTX,
  input  logic [3:0]       FLAGS,
  input  logic [WIDTH-1:0] ALU_R,
  input  logic             WAKE,
  output logic [WIDTH-1:0] PC_A,
  output logic [WIDTH-1:0] PC_NEXT,
  output logic             TAKEN,
`ifdef PC_LINK_EN
  output logic [WIDTH-1:0] LINK,
`endif
  output logic             HALTED
);

  // Phase strobes are single-cycle qualifiers with no back-pressure: a strobe high at a rising
  // edge is consumed on that edge. Overlaps resolve COMMIT > EXECUTE > DECODE > FETCH.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_a_q, pc_a_d;
  logic [WIDTH-1:0] pc_next_q, pc_next_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             taken_q, taken_d;
  logic             cond;
  logic [WIDTH-1:0] target_raw;
`ifdef PC_LINK_EN
  logic [WIDTH-1:0] link_q, link_d;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_RUN;
      pc_a_q    <= RESET_VECTOR;
      pc_next_q <= RESET_VECTOR + WIDTH'(INC);
      target_q  <= '0;
      taken_q   <= 1'b0;
`ifdef PC_LINK_EN
      link_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_a_q    <= pc_a_d;
      pc_next_q <= pc_next_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
`ifdef PC_LINK_EN
      link_q    <= link_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_a_d    = pc_a_q;
    pc_next_d = pc_next_q;
    target_d  = target_q;
    taken_d   = taken_q;
`ifdef PC_LINK_EN
    link_d    = link_q;
`endif
    cond       = FLAGS[CC_SELECTX] ^ CC_INVERTX;
    target_raw = JRX ? (pc_next_q + ALU_R) : ALU_R;

    case (state_q)
      ST_RUN: begin
        if (COMMIT) begin
          if (!PC_EN) begin
            // HALT: PC_A keeps pointing at the halt instruction until WAKE
            state_d = ST_HALTED;
          end else begin
            pc_a_d = taken_q ? target_q : pc_next_q;
`ifdef PC_LINK_EN
            if (taken_q) link_d = pc_next_q;
`endif
          end
        end else if (EXECUTE) begin
          taken_d  = JMP_X | (CC_APPLYX & cond);
          target_d = {target_raw[WIDTH-1:1], 1'b0};
        end else if (FETCH && !DECODE) begin
          pc_next_d = pc_a_q + WIDTH'(INC);
          taken_d   = 1'b0;
        end
      end
      ST_HALTED: begin
        if (WAKE) begin
          state_d = ST_RUN;
          pc_a_d  = pc_next_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign PC_A    = pc_a_q;
  assign PC_NEXT = pc_next_q;
  assign TAKEN   = taken_q;
  assign HALTED  = (state_q == ST_HALTED);
`ifdef PC_LINK_EN
  assign LINK    = link_q;
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Randomised scoreboard bench for program_counter_unit; an instruction-level model predicts
// PC_A/TAKEN/HALTED (and LINK when PC_LINK_EN is defined) after every EXECUTE, COMMIT or WAKE cycle.
module tb_program_counter_unit;
  localparam int W = 16;
  localparam logic [W-1:0] RV = 16'h0100;
  localparam int RW = 2 * W + 2;

  logic         CLK, RESET;
  logic         FETCH, DECODE, EXECUTE, COMMIT;
  logic         PC_EN, JRX, JMP_X, CC_APPLYX, CC_INVERTX, WAKE;
  logic [1:0]   CC_SELECTX;
  logic [3:0]   FLAGS;
  logic [W-1:0] ALU_R, PC_A, PC_NEXT;
  logic         TAKEN, HALTED;
`ifdef PC_LINK_EN
  logic [W-1:0] LINK;
`endif

  program_counter_unit #(.WIDTH(W), .RESET_VECTOR(RV), .INC(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT),
    .PC_EN(PC_EN), .JRX(JRX), .JMP_X(JMP_X), .CC_APPLYX(CC_APPLYX),
    .CC_INVERTX(CC_INVERTX), .CC_SELECTX(CC_SELECTX), .FLAGS(FLAGS),
    .ALU_R(ALU_R), .WAKE(WAKE),
    .PC_A(PC_A), .PC_NEXT(PC_NEXT), .TAKEN(TAKEN),
`ifdef PC_LINK_EN
    .LINK(LINK),
`endif
    .HALTED(HALTED)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // scoreboard: {link, pc, taken, halted}
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] rec;

  // instruction-level reference model
  logic [W-1:0] m_pc;
  logic [W-1:0] m_link;
  logic         m_taken;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] pc, input logic tk, input logic hl);
    exp_q.push_back({m_link, pc, tk, hl});
  endtask

  task automatic rand_ctl();
    PC_EN      = 1'($urandom_range(0, 1));
    JRX        = 1'($urandom_range(0, 1));
    JMP_X      = 1'($urandom_range(0, 1));
    CC_APPLYX  = 1'($urandom_range(0, 1));
    CC_INVERTX = 1'($urandom_range(0, 1));
    CC_SELECTX = 2'($urandom_range(0, 3));
    FLAGS      = 4'($urandom_range(0, 15));
    ALU_R      = W'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic strobes(input logic f, input logic d, input logic e, input logic c, input logic w);
    FETCH = f; DECODE = d; EXECUTE = e; COMMIT = c; WAKE = w;
  endtask

  // One full instruction in RUN; lower-priority strobes are randomly overlapped onto each phase.
  task automatic instr(input logic pc_en, input logic jrx, input logic jmp, input logic apply,
                       input logic inv, input logic [1:0] sel, input logic [3:0] flags,
                       input logic [W-1:0] alu);
    logic         flag, tk, w;
    logic [W-1:0] tgt;
    @(negedge CLK);
    rand_ctl();
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m_taken = 1'b0;

    @(negedge CLK);
    rand_ctl();
    w = ($urandom_range(0, 3) == 0);
    strobes(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, w);
    if (w) push(m_pc, m_taken, 1'b0);

    @(negedge CLK);
    PC_EN = 1'($urandom_range(0, 1)); JRX = jrx; JMP_X = jmp; CC_APPLYX = apply;
    CC_INVERTX = inv; CC_SELECTX = sel; FLAGS = flags; ALU_R = alu;
    strobes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
            1'($urandom_range(0, 1)));
    case (sel)
      2'b00:   flag = flags[0];
      2'b01:   flag = flags[1];
      2'b10:   flag = flags[2];
      default: flag = flags[3];
    endcase
    tk  = jmp | (apply & (flag ^ inv));
    tgt = jrx ? (m_pc + 16'd2 + alu) : alu;
    tgt = tgt & 16'hFFFE;
    m_taken = tk;
    push(m_pc, tk, 1'b0);

    @(negedge CLK);
    rand_ctl();
    PC_EN = pc_en;
    strobes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
            1'($urandom_range(0, 1)));
    if (!pc_en) begin
      push(m_pc, tk, 1'b1);
    end else begin
      if (tk) begin
        m_link = m_pc + 16'd2;
        m_pc   = tgt;
      end else begin
        m_pc = m_pc + 16'd2;
      end
      push(m_pc, tk, 1'b0);
    end
  endtask

  task automatic seq_instr();
    instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
  endtask

  task automatic jump_abs(input logic [W-1:0] a);
    instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, a);
  endtask

  // Cycles spent in HALTED with random strobes, then a WAKE.
  task automatic halt_period(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      rand_ctl();
      strobes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
      if (COMMIT || EXECUTE) push(m_pc, m_taken, 1'b1);
    end
    @(negedge CLK);
    rand_ctl();
    strobes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1);
    m_pc = m_pc + 16'd2;
    push(m_pc, m_taken, 1'b0);
  endtask

  task automatic check_reset_values();
    chk("reset_pc_a", PC_A, RV);
    chk("reset_pc_next", PC_NEXT, RV + 16'd2);
    chk("reset_taken", W'(TAKEN), 16'd0);
    chk("reset_halted", W'(HALTED), 16'd0);
`ifdef PC_LINK_EN
    chk("reset_link", LINK, 16'd0);
`endif
  endtask

  // monitor: one expected record per cycle carrying EXECUTE, COMMIT or WAKE
  always @(posedge CLK) begin
    if (RESET && (COMMIT || EXECUTE || WAKE)) begin
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation for DUT event at %0t", $time);
      end else begin
        rec = exp_q.pop_front();
        chk("pc_a", PC_A, rec[W+1:2]);
        chk("taken", W'(TAKEN), W'(rec[1]));
        chk("halted", W'(HALTED), W'(rec[0]));
`ifdef PC_LINK_EN
        chk("link", LINK, rec[RW-1:W+2]);
`endif
      end
    end
  end

  initial begin
    RESET = 1'b0;
    strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rand_ctl();
    m_pc = RV; m_link = '0; m_taken = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_values();
    RESET = 1'b1;

    // reset asserted in the middle of an EXECUTE cycle
    jump_abs(16'h0200);
    @(negedge CLK); rand_ctl(); strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); m_taken = 1'b0;
    @(negedge CLK); strobes(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    JMP_X = 1'b1; JRX = 1'b0; ALU_R = 16'h3000;
    strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(m_pc, 1'b1, 1'b0);
    @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    m_pc = RV; m_link = '0; m_taken = 1'b0;
    check_reset_values();
    @(negedge CLK);
    strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    seq_instr();

    // four sequential instructions from 0x0000
    jump_abs(16'h0000);
    repeat (4) seq_instr();

    // relative and absolute unconditional jumps
    jump_abs(16'h0010);
    instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'hFFF0);
    instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h1235);

    // conditional on carry, plain and inverted; both jump kinds together
    instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'b0010, 16'h0500);
    instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 4'b0010, 16'h0700);
    instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000, 16'h0900);

    // halt at 0x0040, 20 ignored phase cycles, then wake
    jump_abs(16'h0040);
    instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    halt_period(20);

    // wraparound and link address
    jump_abs(16'hFFFE);
    seq_instr();
    jump_abs(16'h0020);
    jump_abs(16'h0600);

    // random instruction stream
    for (int i = 0; i < 150; i++) begin
      logic pe;
      pe = ($urandom_range(0, 9) != 0);
      instr(pe, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), W'($urandom_range(0, 16'hFFFF)));
      if (!pe) halt_period($urandom_range(0, 6));
    end

    @(negedge CLK);
    strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
